// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control path: opcodes, state
// encodings, PC/writeback select codes and the opcode-class struct.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_IMM  = 2'b01;
  localparam logic [1:0] PC_SRC_ALU  = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  // One-hot opcode class; exactly one bit is set for any opcode.
  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// mc_opclass: combinational opcode -> one-hot instruction class.
// SYSTEM, FENCE and anything outside RV32I land in the illegal class.
import multicycle_ctrl_pkg::*;

module mc_opclass (
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPCODE_OP, OPCODE_OPIMM,
      OPCODE_LUI, OPCODE_AUIPC: cls.alu     = 1'b1;
      OPCODE_LOAD:              cls.load    = 1'b1;
      OPCODE_STORE:             cls.store   = 1'b1;
      OPCODE_BRANCH:            cls.branch  = 1'b1;
      OPCODE_JAL:               cls.jal     = 1'b1;
      OPCODE_JALR:              cls.jalr    = 1'b1;
      default:                  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB with
// memory wait timeout. Define TRAP_ILLEGAL_EN to trap unsupported opcodes.
import multicycle_ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        imm_we,
  output logic        alu_en,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        bus_err,
  output logic        illegal,
  output logic [2:0]  state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wcnt;
  opclass_t      cls;
  logic          at_limit;
  logic          waiting;
  logic          unused_instr;

  assign unused_instr = ^instr[31:7];

  mc_opclass u_opclass (
    .opcode (instr[6:0]),
    .cls    (cls)
  );

  // The access times out on the cycle whose stall would take the count to the limit.
  assign at_limit = (wcnt == CW'(MEM_TIMEOUT - 1));
  assign waiting  = mem_req && !mem_ready;
  assign state_o  = state;

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    imm_we       = 1'b0;
    alu_en       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PC4;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (at_limit) begin
          state_nxt = ST_TRAP;
        end
      end
      ST_DECODE: begin
        imm_we    = 1'b1;
        state_nxt = ST_EXEC;
`ifdef TRAP_ILLEGAL_EN
        if (cls.illegal) state_nxt = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        if (cls.load || cls.store) begin
          state_nxt = ST_MEM;
        end else if (cls.branch) begin
          pc_we     = 1'b1;
          pc_src    = br_taken ? PC_SRC_IMM : PC_SRC_PC4;
          state_nxt = ST_FETCH;
        end else if (cls.alu || cls.jal || cls.jalr) begin
          state_nxt = ST_WB;
        end else begin
          // unsupported opcode retires as a NOP
          pc_we     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.store;
        if (mem_ready) begin
          if (cls.store) begin
            pc_we     = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (at_limit) begin
          state_nxt = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        wb_sel    = cls.load ? WB_SEL_LOAD : (cls.jal || cls.jalr) ? WB_SEL_PC4 : WB_SEL_ALU;
        pc_src    = cls.jal ? PC_SRC_IMM : cls.jalr ? PC_SRC_ALU : PC_SRC_PC4;
        state_nxt = ST_FETCH;
      end
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == ST_FETCH || state_nxt == ST_MEM) && state_nxt != state)
        wcnt <= '0;
      else if (waiting && wcnt != CW'(MEM_TIMEOUT))
        wcnt <= wcnt + 1'b1;
      if (waiting && at_limit)
        bus_err <= 1'b1;
    end
  end

`ifdef TRAP_ILLEGAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal <= 1'b0;
    else if (state == ST_DECODE && cls.illegal)
      illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the
// sequencing rules, replayed cycle by cycle with random wait states and noise.
module tb_multicycle_ctrl;

  localparam int TO = 15;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
`ifdef TRAP_ILLEGAL_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0;
  logic br_taken = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, mem_addr_sel, ir_we, imm_we, alu_en, reg_we, pc_we, bus_err, illegal;
  logic [1:0] wb_sel, pc_src;
  logic [2:0] state_o;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .imm_we(imm_we), .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_src(pc_src), .bus_err(bus_err), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic be_m = 1'b0, il_m = 1'b0;

  typedef struct {
    logic [2:0]  st;
    logic        rdy;
    logic        br;
    logic [31:0] ins;
    logic [13:0] o;
  } cyc_t;
  cyc_t q[$];

  // instruction kinds: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 jalr, 6 illegal
  function automatic int kind(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h37, 7'h17: return 0;
      7'h03: return 1;
      7'h23: return 2;
      7'h63: return 3;
      7'h6F: return 4;
      7'h67: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [13:0] pk(input bit req, we, as, irw, immw, alu, rw,
                                     input logic [1:0] wb, input bit pw, input logic [1:0] ps);
    return {req, we, as, irw, immw, alu, rw, wb, pw, ps, be_m, il_m};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [31:0] rw32();
    return 32'($urandom);
  endfunction

  task automatic push(input logic [2:0] st, input bit rdy, input logic [31:0] ins, input logic [13:0] o,
                      input bit br = 1'b0);
    q.push_back('{st, rdy, br, ins, o});
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) push(S_TRAP, rb(), rw32(), pk(0,0,0,0,0,0,0,2'b00,0,2'b00), rb());
  endtask

  // Expected cycle trace for one instruction; fw/mw = stall cycles before ready (>= TO: never ready).
  task automatic gen(input logic [31:0] ins, input int fw, input int mw);
    int k;
    bit br, rdy;
    logic [1:0] wb, ps;
    k = kind(ins[6:0]);
    if (fw >= TO) begin
      for (int i = 0; i < TO; i++) push(S_FETCH, 0, rw32(), pk(1,0,0,0,0,0,0,2'b00,0,2'b00), rb());
      be_m = 1'b1;
      trap_cycles(3);
      return;
    end
    for (int i = 0; i <= fw; i++) begin
      rdy = (i == fw);
      push(S_FETCH, rdy, rw32(), pk(1,0,0,rdy,0,0,0,2'b00,0,2'b00), rb());
    end
    push(S_DECODE, rb(), ins, pk(0,0,0,0,1,0,0,2'b00,0,2'b00), rb());
    if (k == 6 && TRAP_EN) begin
      il_m = 1'b1;
      trap_cycles(3);
      return;
    end
    br = rb();
    case (k)
      3: begin push(S_EXEC, rb(), ins, pk(0,0,0,0,0,1,0,2'b00,1,br ? 2'b01 : 2'b00), br); return; end
      6: begin push(S_EXEC, rb(), ins, pk(0,0,0,0,0,1,0,2'b00,1,2'b00), br); return; end
      default: push(S_EXEC, rb(), ins, pk(0,0,0,0,0,1,0,2'b00,0,2'b00), br);
    endcase
    if (k == 1 || k == 2) begin
      if (mw >= TO) begin
        for (int i = 0; i < TO; i++) push(S_MEM, 0, ins, pk(1,k == 2,1,0,0,0,0,2'b00,0,2'b00), rb());
        be_m = 1'b1;
        trap_cycles(3);
        return;
      end
      for (int i = 0; i <= mw; i++) begin
        rdy = (i == mw);
        push(S_MEM, rdy, ins, pk(1,k == 2,1,0,0,0,0,2'b00,(k == 2) && rdy,2'b00), rb());
      end
      if (k == 2) return;
    end
    wb = (k == 1) ? 2'b01 : (k == 4 || k == 5) ? 2'b10 : 2'b00;
    ps = (k == 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
    push(S_WB, rb(), ins, pk(0,0,0,0,0,0,1,wb,1,ps), rb());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {mem_req, mem_we, mem_addr_sel, ir_we, imm_we, alu_en, reg_we, wb_sel, pc_we, pc_src,
            bus_err, illegal};
  endfunction

  // Called #1 after a rising edge; drives the cycle, checks mid-cycle, advances one clock.
  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      instr = c.ins; mem_ready = c.rdy; br_taken = c.br;
      #3;
      chk($sformatf("state@%0d", c.st), 32'(state_o), 32'(c.st));
      chk($sformatf("outs@st%0d", c.st), 32'(outs()), 32'(c.o));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_outs", 32'(outs()), 32'd0);
    q.delete(); be_m = 1'b0; il_m = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("idle_state", 32'(state_o), 32'(S_IDLE));
    chk("idle_outs", 32'(outs()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [6:0]  ops[12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                           7'h73, 7'h0F, 7'h7F};
  logic [31:0] r;

  initial begin
    #3;
    chk("por_state", 32'(state_o), 32'(S_IDLE));
    chk("por_outs", 32'(outs()), 32'd0);
    @(negedge clk); do_reset();

    gen(32'h00500093, 0, 0);  run_all();   // ADDI x1,x0,5
    gen(32'h0000a103, 0, 3);  run_all();   // LW, 3 stalls in MEM
    gen(32'h00208463, 0, 0);  run_all();   // BEQ
    gen(32'h00208463, 1, 0);  run_all();
    gen(32'h000080e7, 0, 0);  run_all();   // JALR
    gen(32'h008000ef, 2, 0);  run_all();   // JAL
    gen(32'h0020a023, 1, 2);  run_all();   // SW
    gen(32'h0000a103, TO - 1, TO - 1); run_all();  // ready on the last permitted cycle

    for (int n = 0; n < 40; n++) begin
      r = rw32();
      gen({r[31:7], ops[$urandom_range(TRAP_EN ? 8 : 11, 0)]}, $urandom_range(3, 0), $urandom_range(3, 0));
      run_all();
    end

    // async reset in the middle of a stalled load
    gen(32'h0000a103, 0, 10);
    run_n(5);
    do_reset();

    gen(32'h0000007F, 0, 0); run_all();
    gen(32'h00500093, 0, 0); run_all();
    do_reset();

    gen(32'h00500093, TO, 0); run_all();   // fetch never ready
    do_reset();
    gen(32'h0020a023, 0, TO); run_all();   // store never ready
    do_reset();
    gen(32'h00500093, 0, 0); run_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
